// File: rtl/bool_oai_pipe_if.sv
// bool_oai_pipe_if
// Operand/result bundle for bool_oai_pipe.
//   master modport : operand producer + result consumer side
//                    (drives in_valid, a, b, c, mode, out_ready)
//   slave modport  : the pipeline itself
//                    (drives in_ready, out_valid, e, ones, total)
// WIDTH and CNT_W must match the parameters of the attached pipeline.
interface bool_oai_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  localparam int ONES_W = $clog2(WIDTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [WIDTH-1:0]  c;
  logic [1:0]        mode;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  e;
  logic [ONES_W-1:0] ones;
  logic [CNT_W-1:0]  total;

  modport master (
    output in_valid, a, b, c, mode, out_ready,
    input  in_ready, out_valid, e, ones, total
  );

  modport slave (
    input  in_valid, a, b, c, mode, out_ready,
    output in_ready, out_valid, e, ones, total
  );
endinterface

// File: rtl/bool_oai_pipe.sv
// bool_oai_pipe
// Two-stage valid/ready pipeline evaluating a per-bit four-mode boolean
// function on WIDTH-bit operands:
//   mode 0: ~((a|b)&c)   mode 1: (a|b)&c
//   mode 2: ~((a&b)|c)   mode 3: (a&b)|c
// Stage 1 captures operands on accept; stage 2 holds the result, its
// popcount and drives the output side. A saturating counter tracks
// completed output transfers.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : bool_oai_pipe_if.slave (operands, mode, handshakes, e, ones, total)
module bool_oai_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  bool_oai_pipe_if.slave  bus
);
  localparam int ONES_W = $clog2(WIDTH + 1);

  // Stage 1 registers
  logic              r_s1_valid;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_c;
  logic [1:0]        r_mode;

  // Stage 2 registers
  logic              r_s2_valid;
  logic [WIDTH-1:0]  r_e;
  logic [ONES_W-1:0] r_ones;

  logic [CNT_W-1:0]  r_total;

  logic              w_s1_adv;
  logic              w_in_ready;
  logic              w_out_fire;
  logic [WIDTH-1:0]  w_oa;   // (a|b)&c
  logic [WIDTH-1:0]  w_ao;   // (a&b)|c
  logic [WIDTH-1:0]  w_f;
  logic [ONES_W-1:0] w_ones;

  // S1 may hand its beat to S2 when S2 is empty or draining this cycle.
  assign w_s1_adv   = r_s1_valid & (~r_s2_valid | bus.out_ready);
  // Depends only on state and out_ready, never on in_valid.
  assign w_in_ready = ~r_s1_valid | w_s1_adv;
  assign w_out_fire = r_s2_valid & bus.out_ready;

  // mode[1] picks the gate form, mode[0]=0 means the inverted output.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_oa[gi] = (r_a[gi] | r_b[gi]) & r_c[gi];
      assign w_ao[gi] = (r_a[gi] & r_b[gi]) | r_c[gi];
      assign w_f[gi]  = r_mode[1] ? (r_mode[0] ? w_ao[gi] : ~w_ao[gi])
                                  : (r_mode[0] ? w_oa[gi] : ~w_oa[gi]);
    end
  endgenerate

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ones = w_ones + ONES_W'(w_f[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_mode     <= '0;
      r_s2_valid <= 1'b0;
      r_e        <= '0;
      r_ones     <= '0;
      r_total    <= '0;
    end else begin
      if (w_in_ready) begin
        r_s1_valid <= bus.in_valid;
        // Operand registers only change on an actual accept.
        if (bus.in_valid) begin
          r_a    <= bus.a;
          r_b    <= bus.b;
          r_c    <= bus.c;
          r_mode <= bus.mode;
        end
      end

      if (w_s1_adv) begin
        r_e        <= w_f;
        r_ones     <= w_ones;
        r_s2_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_s2_valid <= 1'b0;
      end

      // Saturate at all-ones rather than wrapping.
      if (w_out_fire && (r_total != '1)) begin
        r_total <= r_total + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.e         = r_e;
  assign bus.ones      = r_ones;
  assign bus.total     = r_total;
endmodule

// File: tb/tb_bool_oai_pipe.sv
module tb_bool_oai_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bool_oai_pipe_if #(.WIDTH(8), .CNT_W(16)) if8 ();
  bool_oai_pipe_if #(.WIDTH(8), .CNT_W(3))  if3 ();

  bool_oai_pipe #(.WIDTH(8), .CNT_W(16)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  bool_oai_pipe #(.WIDTH(8), .CNT_W(3))  dut3 (.clk(clk), .rst(rst), .bus(if3));

  // Reference model of the per-bit function.
  function automatic logic [7:0] ref_e(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [1:0] m);
    case (m)
      2'd0:    return ~((a | b) & c);
      2'd1:    return (a | b) & c;
      2'd2:    return ~((a & b) | c);
      default: return (a & b) | c;
    endcase
  endfunction

  function automatic int pop8(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [1:0] m);
    if8.in_valid = v;
    if8.a        = a;
    if8.b        = b;
    if8.c        = c;
    if8.mode     = m;
  endtask

  task automatic test_reset();
    drive8(1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    if8.out_ready = 1'b0;
    if3.in_valid  = 1'b0;
    if3.a = 8'h00; if3.b = 8'h00; if3.c = 8'h00; if3.mode = 2'd0;
    if3.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", if8.out_valid); end
    checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", if8.in_ready); end
    checks++; if (if8.e !== 8'h00) begin errors++; $display("FAIL reset_e got=%h exp=00", if8.e); end
    checks++; if (if8.ones !== 4'd0) begin errors++; $display("FAIL reset_ones got=%0d exp=0", if8.ones); end
    checks++; if (if8.total !== 16'd0) begin errors++; $display("FAIL reset_total got=%0d exp=0", if8.total); end
    $display("reset done");
  endtask

  task automatic test_single();
    drive8(1'b1, 8'h0F, 8'h30, 8'hFF, 2'd0);
    if8.out_ready = 1'b0;
    #1;
    checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got=%0b exp=1", if8.in_ready); end
    tick();
    drive8(1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%0b exp=0", if8.out_valid); end
    tick();
    checks++; if (if8.out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%0b exp=1", if8.out_valid); end
    checks++; if (if8.e !== 8'hC0) begin errors++; $display("FAIL single_e got=%h exp=c0", if8.e); end
    checks++; if (if8.ones !== 4'd2) begin errors++; $display("FAIL single_ones got=%0d exp=2", if8.ones); end
    checks++; if (if8.total !== 16'd0) begin errors++; $display("FAIL single_total_pre got=%0d exp=0", if8.total); end
    $display("single beat e=%h ones=%0d", if8.e, if8.ones);
    if8.out_ready = 1'b1;
    tick();
    checks++; if (if8.total !== 16'd1) begin errors++; $display("FAIL single_total got=%0d exp=1", if8.total); end
    checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL single_drained got=%0b exp=0", if8.out_valid); end
  endtask

  task automatic test_modes();
    // a=AA b=CC c=F0: a|b=EE, (a|b)&c=E0, a&b=88, (a&b)|c=F8
    logic [7:0] exp_e [4];
    int         exp_o [4];
    exp_e[0] = 8'h1F; exp_o[0] = 5;
    exp_e[1] = 8'hE0; exp_o[1] = 3;
    exp_e[2] = 8'h07; exp_o[2] = 3;
    exp_e[3] = 8'hF8; exp_o[3] = 5;
    if8.out_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc < 4) drive8(1'b1, 8'hAA, 8'hCC, 8'hF0, 2'(cyc));
      else         drive8(1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
      tick();
      if (cyc >= 1) begin
        checks++; if (if8.out_valid !== 1'b1) begin errors++; $display("FAIL mode%0d_valid got=%0b exp=1", cyc-1, if8.out_valid); end
        checks++; if (if8.e !== exp_e[cyc-1]) begin errors++; $display("FAIL mode%0d_e got=%h exp=%h", cyc-1, if8.e, exp_e[cyc-1]); end
        checks++; if (int'(if8.ones) != exp_o[cyc-1]) begin errors++; $display("FAIL mode%0d_ones got=%0d exp=%0d", cyc-1, if8.ones, exp_o[cyc-1]); end
        $display("mode %0d e=%h ones=%0d", cyc-1, if8.e, if8.ones);
      end
    end
    tick();
    checks++; if (if8.total !== 16'd5) begin errors++; $display("FAIL modes_total got=%0d exp=5", if8.total); end
  endtask

  task automatic test_stream();
    logic [7:0] exp_e [16];
    logic [7:0] ra, rb, rc;
    logic [1:0] rm;
    if8.out_ready = 1'b1;
    for (int cyc = 0; cyc <= 16; cyc++) begin
      if (cyc < 16) begin
        ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
        rm = 2'($urandom_range(0, 3));
        exp_e[cyc] = ref_e(ra, rb, rc, rm);
        drive8(1'b1, ra, rb, rc, rm);
      end else begin
        drive8(1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
      end
      #1;
      checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cyc=%0d got=%0b exp=1", cyc, if8.in_ready); end
      tick();
      if (cyc >= 1) begin
        checks++; if (if8.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid beat=%0d got=%0b exp=1", cyc-1, if8.out_valid); end
        checks++; if (if8.e !== exp_e[cyc-1]) begin errors++; $display("FAIL stream_e beat=%0d got=%h exp=%h", cyc-1, if8.e, exp_e[cyc-1]); end
        checks++; if (int'(if8.ones) != pop8(exp_e[cyc-1])) begin errors++; $display("FAIL stream_ones beat=%0d got=%0d exp=%0d", cyc-1, if8.ones, pop8(exp_e[cyc-1])); end
        $display("stream beat %0d e=%h ones=%0d", cyc-1, if8.e, if8.ones);
      end
    end
    tick();
    checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drained got=%0b exp=0", if8.out_valid); end
    checks++; if (if8.total !== 16'd21) begin errors++; $display("FAIL stream_total got=%0d exp=21", if8.total); end
  endtask

  task automatic test_back_to_back();
    // A -> C0/2, B -> F8/5, junk J -> FF/8 (must never appear), D -> FF/8
    if8.out_ready = 1'b0;
    drive8(1'b1, 8'h0F, 8'h30, 8'hFF, 2'd0);   // A
    tick();
    drive8(1'b1, 8'hAA, 8'hCC, 8'hF0, 2'd3);   // B
    #1;
    checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL stall_fill_ready got=%0b exp=1", if8.in_ready); end
    tick();
    drive8(1'b1, 8'hFF, 8'hFF, 8'hFF, 2'd1);   // junk offered while full
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (if8.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready k=%0d got=%0b exp=0", k, if8.in_ready); end
      checks++; if (if8.e !== 8'hC0 || if8.out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold k=%0d got=%h/%0b exp=c0/1", k, if8.e, if8.out_valid); end
      if8.mode = 2'(k);                         // changes while blocked
      tick();
    end
    // Full and consumed in the same cycle: a new beat D enters.
    if8.out_ready = 1'b1;
    drive8(1'b1, 8'h00, 8'h00, 8'h00, 2'd2);   // D
    #1;
    checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL full_consume_ready got=%0b exp=1", if8.in_ready); end
    checks++; if (if8.e !== 8'hC0) begin errors++; $display("FAIL b2b_A got=%h exp=c0", if8.e); end
    $display("b2b beat A e=%h", if8.e);
    tick();
    drive8(1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    checks++; if (if8.e !== 8'hF8 || if8.ones !== 4'd5) begin errors++; $display("FAIL b2b_B got=%h/%0d exp=f8/5", if8.e, if8.ones); end
    $display("b2b beat B e=%h", if8.e);
    tick();
    checks++; if (if8.e !== 8'hFF || if8.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_D got=%h/%0b exp=ff/1", if8.e, if8.out_valid); end
    $display("b2b beat D e=%h", if8.e);
    tick();
    checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got=%0b exp=0", if8.out_valid); end
    checks++; if (if8.total !== 16'd24) begin errors++; $display("FAIL b2b_total got=%0d exp=24", if8.total); end
  endtask

  task automatic test_saturate();
    // Beat i offered before edge i+1, transferred at edge i+3.
    if3.out_ready = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      if3.in_valid = (k <= 10);
      if3.a = 8'(k);
      tick();
      if (k == 8) begin
        checks++; if (if3.total !== 3'd6) begin errors++; $display("FAIL sat_total_6 got=%0d exp=6", if3.total); end
      end
      if (k == 9) begin
        checks++; if (if3.total !== 3'd7) begin errors++; $display("FAIL sat_total_7 got=%0d exp=7", if3.total); end
      end
    end
    checks++; if (if3.total !== 3'd7) begin errors++; $display("FAIL sat_hold got=%0d exp=7", if3.total); end
    $display("saturating counter total=%0d", if3.total);
    if3.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    if8.out_ready = 1'b0;
    drive8(1'b1, 8'h0F, 8'h30, 8'hFF, 2'd0);
    tick();
    drive8(1'b1, 8'hAA, 8'hCC, 8'hF0, 2'd3);
    tick();
    drive8(1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    checks++; if (if8.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_full got=%0b exp=1", if8.out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if8.out_ready = 1'b1;
    #1;
    checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%0b exp=0", if8.out_valid); end
    checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%0b exp=1", if8.in_ready); end
    checks++; if (if8.total !== 16'd0) begin errors++; $display("FAIL rstmid_total got=%0d exp=0", if8.total); end
    checks++; if (if8.e !== 8'h00 || if8.ones !== 4'd0) begin errors++; $display("FAIL rstmid_e got=%h/%0d exp=00/0", if8.e, if8.ones); end
    tick();
    tick();
    checks++; if (if8.out_valid !== 1'b0 || if8.total !== 16'd0) begin errors++; $display("FAIL rstmid_discard got=%0b/%0d exp=0/0", if8.out_valid, if8.total); end
    $display("reset mid-operation total=%0d", if8.total);
  endtask

  initial begin
    test_reset();
    test_single();
    test_modes();
    test_stream();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
